// File: rtl/usb_auto_pkg.sv
// Shared encodings for the USB speed auto-detect sequencer: FSM states, speed codes, linestate codes.
package usb_auto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHIRP  = 3'd3,
    ST_DONE   = 3'd4
  } auto_state_e;

  // Speed code doubles as the PHY xcvrsel value for the detected speed.
  localparam logic [1:0] SPEED_HS   = 2'd0;
  localparam logic [1:0] SPEED_FS   = 2'd1;
  localparam logic [1:0] SPEED_LS   = 2'd2;
  localparam logic [1:0] SPEED_AUTO = 2'd3;

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

endpackage

// File: rtl/usb_chirp_detector.sv
// HS chirp qualifier: hold counter, K-seen flag and K-J pair counter.
// With USB_AUTO_CHIRP_COUNT_EN the pair counter runs to 255 instead of stopping at PAIRS.
module usb_chirp_detector
  import usb_auto_pkg::*;
#(
  parameter int MIN_CYCLES = 1500,
  parameter int PAIRS      = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       fe_clk,
  input  logic       reset_i,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] linestate,
  output logic [7:0] pair_count,
  output logic       hs_found
);

`ifdef USB_AUTO_CHIRP_COUNT_EN
  localparam int PAIR_MAX = 255;
`else
  localparam int PAIR_MAX = PAIRS;
`endif

  logic [CNT_WIDTH-1:0] hold_cnt;
  logic [CNT_WIDTH-1:0] hold_nxt;
  logic [1:0]           prev_ls;
  logic                 k_seen;
  logic                 qual;
  logic [7:0]           pair_nxt;

  // hold_nxt is the length of the current run including this sample
  always_comb begin
    hold_nxt = hold_cnt;
    if (linestate != prev_ls)
      hold_nxt = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else if (hold_cnt != '1)
      hold_nxt = hold_cnt + 1'b1;
    qual = (hold_nxt >= CNT_WIDTH'(MIN_CYCLES));
    pair_nxt = pair_count;
    if (enable && k_seen && linestate == LS_J && qual && pair_count < 8'(PAIR_MAX))
      pair_nxt = pair_count + 8'd1;
    hs_found = enable && (pair_nxt >= 8'(PAIRS));
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      hold_cnt   <= '0;
      prev_ls    <= LS_SE0;
      k_seen     <= 1'b0;
      pair_count <= 8'd0;
    end else if (clear) begin
      hold_cnt   <= '0;
      prev_ls    <= LS_SE0;
      k_seen     <= 1'b0;
      pair_count <= 8'd0;
    end else if (enable) begin
      hold_cnt   <= hold_nxt;
      prev_ls    <= linestate;
      pair_count <= pair_nxt;
      if (linestate == LS_K && qual)
        k_seen <= 1'b1;
      else if (linestate == LS_J && qual && k_seen)
        k_seen <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_speed_autodetect.sv
// USB bus-speed auto-detect sequencer (fe_clk domain).
// Optional USB_AUTO_CHIRP_COUNT_EN: adds O_chirp_count and defers the HS decision to window expiry.
//
// state  | meaning
// IDLE   | no detection running, last result held
// SETTLE | PHY in default mode, counting down wait1
// SAMPLE | one-cycle idle linestate classification
// CHIRP  | counting K-J chirp pairs inside the wait2 window
// DONE   | result latched, pulse done and return to IDLE
module usb_speed_autodetect
  import usb_auto_pkg::*;
#(
  parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
  parameter int pCHIRP_MIN_CYCLES       = 1500,
  parameter int pCHIRP_PAIRS            = 3,
  parameter int pCHIRP_CNT_WIDTH        = 16
) (
  input  logic                               fe_clk,
  input  logic                               reset_i,
  input  logic                               I_restart,
  input  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait1,
  input  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait2,
  input  logic [1:0]                         I_xcvrsel_default,
  input  logic                               I_termsel_default,
  input  logic [1:0]                         I_linestate,
  output logic [1:0]                         O_usb_auto_speed,
  output logic [1:0]                         O_xcvrsel,
  output logic                               O_termsel,
  output logic                               O_busy,
  output logic                               O_done
`ifdef USB_AUTO_CHIRP_COUNT_EN
  ,output logic [7:0]                        O_chirp_count
`endif
);

  auto_state_e                        state;
  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] wait_cnt;
  logic [1:0]                         ls_q;
  logic                               hs_found;
  logic                               latch_en;
  logic [1:0]                         latch_speed;

`ifdef USB_AUTO_CHIRP_COUNT_EN
  logic [7:0] pair_count;
  assign O_chirp_count = pair_count;
`else
  logic [7:0] pair_count_unused;
`endif

  usb_chirp_detector #(
    .MIN_CYCLES (pCHIRP_MIN_CYCLES),
    .PAIRS      (pCHIRP_PAIRS),
    .CNT_WIDTH  (pCHIRP_CNT_WIDTH)
  ) u_chirp (
    .fe_clk     (fe_clk),
    .reset_i    (reset_i),
    .clear      (I_restart),
    .enable     (state == ST_CHIRP),
    .linestate  (ls_q),
`ifdef USB_AUTO_CHIRP_COUNT_EN
    .pair_count (pair_count),
`else
    .pair_count (pair_count_unused),
`endif
    .hs_found   (hs_found)
  );

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) ls_q <= LS_J;
    else         ls_q <= I_linestate;
  end

  // HS beats window expiry when both resolve in the same cycle
  always_comb begin
    latch_en    = 1'b0;
    latch_speed = SPEED_FS;
    if (state == ST_SAMPLE && ls_q == LS_K) begin
      latch_en    = 1'b1;
      latch_speed = SPEED_LS;
    end else if (state == ST_CHIRP) begin
`ifdef USB_AUTO_CHIRP_COUNT_EN
      if (wait_cnt == '0) begin
        latch_en    = 1'b1;
        latch_speed = hs_found ? SPEED_HS : SPEED_FS;
      end
`else
      if (hs_found) begin
        latch_en    = 1'b1;
        latch_speed = SPEED_HS;
      end else if (wait_cnt == '0) begin
        latch_en    = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      O_usb_auto_speed <= SPEED_FS;
      O_xcvrsel        <= SPEED_FS;
      O_termsel        <= 1'b1;
      O_busy           <= 1'b0;
      O_done           <= 1'b0;
    end else begin
      O_done <= 1'b0;
      if (I_restart) begin
        state     <= ST_SETTLE;
        wait_cnt  <= I_wait1;
        O_xcvrsel <= I_xcvrsel_default;
        O_termsel <= I_termsel_default;
        O_busy    <= 1'b1;
      end else if (latch_en) begin
        O_usb_auto_speed <= latch_speed;
        O_xcvrsel        <= latch_speed;
        O_termsel        <= (latch_speed != SPEED_HS);
        state            <= ST_DONE;
      end else begin
        case (state)
          ST_SETTLE: begin
            if (wait_cnt == '0) state <= ST_SAMPLE;
            else                wait_cnt <= wait_cnt - 1'b1;
          end
          ST_SAMPLE: begin
            // SE1 is treated as a glitch: settle again and resample
            if (ls_q == LS_SE1) begin
              wait_cnt <= I_wait1;
              state    <= ST_SETTLE;
            end else begin
              wait_cnt <= I_wait2;
              state    <= ST_CHIRP;
            end
          end
          ST_CHIRP: wait_cnt <= wait_cnt - 1'b1;
          ST_DONE: begin
            O_done <= 1'b1;
            O_busy <= 1'b0;
            state  <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_speed_autodetect.md
Name: usb_speed_autodetect

Overview:
Sequences USB bus-speed auto-detection for the sniffer frontend in the fe_clk domain. On a restart it drives the PHY into a default full-speed listening mode and waits a settle time. It then classifies the bus as LS, FS or HS from idle line state and the HS chirp handshake, and reports the detected speed plus the xcvrsel/termsel values the top level applies to the PHY. Wait times and defaults come from the USB register block.

Parameters:
pUSB_AUTO_COUNTER_WIDTH, 24, width of wait1/wait2 counters
pCHIRP_MIN_CYCLES, 1500, minimum fe_clk cycles a chirp K or J must hold (25 us at 60 MHz)
pCHIRP_PAIRS, 3, K-J chirp pairs required to declare HS
pCHIRP_CNT_WIDTH, 16, width of the chirp hold counter

Ports:
fe_clk  in  1  frontend clock; sole clock
reset_i  in  1  asynchronous, active-high reset
I_restart  in  1  single-cycle pulse, already synchronous to fe_clk; starts or restarts detection
I_wait1  in  pUSB_AUTO_COUNTER_WIDTH  settle cycles before idle sampling
I_wait2  in  pUSB_AUTO_COUNTER_WIDTH  chirp window length in cycles
I_xcvrsel_default  in  2  xcvrsel applied while detecting
I_termsel_default  in  1  termsel applied while detecting
I_linestate  in  2  PHY linestate: 00 SE0, 01 J(FS), 10 K/LS-idle, 11 SE1
O_usb_auto_speed  out  2  detected speed: 00 HS, 01 FS, 10 LS
O_xcvrsel  out  2  PHY xcvrsel
O_termsel  out  1  PHY termsel
O_busy  out  1  high while detection runs
O_done  out  1  one-cycle pulse when a result is latched

Behaviour:
- Reset values: state IDLE, O_usb_auto_speed=01, O_xcvrsel=01, O_termsel=1, O_busy=0, O_done=0.
- I_linestate is registered once before use, adding 1 cycle of latency to every sample.
- States: IDLE, SETTLE, SAMPLE, CHIRP, DONE.
- I_restart in any state:
  - Next state is SETTLE.
  - Load the wait counter with I_wait1 and clear the chirp counters.
  - Drive O_xcvrsel/O_termsel from the defaults.
  - Set O_busy=1.
  - O_usb_auto_speed holds its previous result until a new one is latched.
- SETTLE: decrement the counter each cycle. At 0, go to SAMPLE. I_wait1=0 means SAMPLE on the next cycle.
- SAMPLE (one cycle), keyed on the registered linestate:
  - 01: load the counter with I_wait2 and go to CHIRP.
  - 10: result LS.
  - 00: go to CHIRP, since a bus reset is in progress.
  - 11: return to SETTLE with I_wait1 reloaded (glitch retry, unbounded).
- CHIRP:
  - Decrement the window counter each cycle.
  - The hold counter counts consecutive cycles of the same linestate (saturating) and resets on change.
  - A K whose hold reaches pCHIRP_MIN_CYCLES arms "K seen".
  - A subsequent qualified J increments the pair count and clears "K seen".
  - Pair count reaching pCHIRP_PAIRS gives result HS.
  - Window reaching 0 first gives result FS. I_wait2=0 gives FS on the next cycle.
  - If the window expiry and the final qualifying J land in the same cycle, HS wins.
- Result latch (entering DONE):
  - Set O_usb_auto_speed.
  - O_xcvrsel = speed code (HS 00, FS 01, LS 10).
  - O_termsel = 0 for HS, 1 otherwise.
  - Pulse O_done for 1 cycle, drop O_busy, and go to IDLE.
- The chirp pair counter saturates at pCHIRP_PAIRS and the hold counter saturates at all-ones. Neither wraps.

Optional Feature:
USB_AUTO_CHIRP_COUNT_EN
- Defined:
  - Adds output O_chirp_count[7:0], the number of qualified K-J pairs in the last detection, saturating at 255.
  - Cleared on I_restart and held after DONE.
  - In this mode, HS is declared only at window expiry: pairs >= pCHIRP_PAIRS gives HS, otherwise FS.
- Undefined: the port is absent and the early HS exit applies.

Decomposition:
- Package usb_auto_pkg holds:
  - state encoding;
  - speed codes HS/FS/LS/AUTO = 0/1/2/3;
  - linestate codes SE0/J/K/SE1.
- One sub-module, usb_chirp_detector, holds the hold counter, K-seen flag and pair counter. It takes clear, enable and linestate, and outputs pair_count and hs_found.

Test Plan:
(Benches override pCHIRP_MIN_CYCLES=4 and pCHIRP_PAIRS=3 throughout.)
1. Reset, no restart -> speed=01, xcvrsel=01, termsel=1, busy=0, no done pulse.
2. Restart, wait1=10, linestate held at 10 -> done exactly 13 cycles after restart: 10 settle cycles, 1 register stage, 1 SAMPLE cycle, 1 DONE cycle. Expect speed=10, xcvrsel=10, termsel=1.
3. Restart, wait1=10, wait2=1000, linestate 01 then 3 pairs of K×6 / J×6 -> speed=00, xcvrsel=00, termsel=0. Done occurs before the window expires.
4. As scenario 3 but chirps held only 3 cycles each -> window expires, speed=01, done pulse near 1000 cycles after SAMPLE.
5. Linestate 11 at SAMPLE, then 01 with wait2=0 -> one extra settle of 10 cycles, then speed=01.
6. Restart asserted mid-CHIRP after 2 pairs -> counters cleared. A fresh sequence with 2 pairs gives FS. With USB_AUTO_CHIRP_COUNT_EN, O_chirp_count=2.
